// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: FSM states and op selector.
package mul_div_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic OP_MULU = 1'b0;
    localparam logic OP_DIVU = 1'b1;

endpackage

// File: rtl/mul_div_unit_md_step.sv
// One combinational iteration: shift-add for multiply, restoring compare-subtract-shift for divide.
module md_step
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             op_div_i,
    input  logic [WIDTH-1:0] hi_i,       // product upper half / running remainder
    input  logic [WIDTH-1:0] lo_i,       // multiplier bits / dividend bits becoming quotient
    input  logic [WIDTH-1:0] operand_i,  // multiplicand / divisor
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, operand_i} : '0);
        // Partial remainder needs WIDTH+1 bits: 2*rem+bit can reach 2*divisor-1.
        shifted = {hi_i, lo_i[WIDTH-1]};
        diff    = shifted - {1'b0, operand_i};
        hi_o    = '0;
        lo_o    = '0;
        if (op_div_i == OP_MULU) begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end else if (diff[WIDTH]) begin
            hi_o = shifted[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b0};
        end else begin
            hi_o = diff[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide: one md_step per cycle for WIDTH cycles, result held until next start.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output state_e           dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic             op_q;
    logic [WIDTH-1:0] operand_q;
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dbz_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] acc_hi_d;
    logic [WIDTH-1:0] acc_lo_d;

    md_step #(.WIDTH(WIDTH)) u_step (
        .op_div_i  (op_q),
        .hi_i      (acc_hi_q),
        .lo_i      (acc_lo_q),
        .operand_i (operand_q),
        .hi_o      (acc_hi_d),
        .lo_o      (acc_lo_d)
    );

    // Working accumulators are separate from hi/lo so results stay stable while iterating.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_MULU;
            operand_q <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q      <= op_div;
                        operand_q <= rt_val;
                        acc_hi_q  <= '0;
                        acc_lo_q  <= rs_val;
                        cnt_q     <= '0;
                        dbz_q     <= 1'b0;
                        if (op_div == OP_DIVU && rt_val == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            hi_q    <= rs_val;
                            lo_q    <= '1;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    acc_hi_q <= acc_hi_d;
                    acc_lo_q <= acc_lo_d;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        hi_q    <= acc_hi_d;
                        lo_q    <= acc_lo_d;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: cycle-accurate latency, result values, ignored starts and mid-run reset.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op_div;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;
  state_e      dbg_state;

  int errors = 0;
  int checks = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op_div      (op_div),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start is sampled at the edge ending cycle 0; sampling happens 1 time unit after each edge.
  task automatic run_op(input string tag, input logic op, input logic [31:0] a, input logic [31:0] b,
                        input int inj_cyc, input int rst_cyc,
                        input int exp_done_cyc, input int exp_busy_n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz);
    int busy_n;
    int done_n;
    int done_at;
    logic [31:0] got_hi;
    logic [31:0] got_lo;
    logic        got_dbz;
    busy_n = 0; done_n = 0; done_at = 0;
    got_hi = '0; got_lo = '0; got_dbz = 1'b0;
    @(negedge clk);
    start = 1'b1; op_div = op; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; op_div = ~op; rs_val = $urandom; rt_val = $urandom;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = cyc;
        got_hi = hi; got_lo = lo; got_dbz = div_by_zero;
      end
      if (rst_cyc > 0 && cyc == rst_cyc + 1) begin
        reset = 1'b0;
        check_eq({tag, " rst state"}, 64'(dbg_state), 64'(ST_IDLE));
        check_eq({tag, " rst outs"}, {busy, done, div_by_zero, hi, lo}, 64'd0);
      end
      if (inj_cyc > 0 && cyc == inj_cyc) begin
        start = 1'b1; op_div = OP_MULU; rs_val = 32'd1000; rt_val = 32'd3;
      end
      if (inj_cyc > 0 && cyc == inj_cyc + 1) start = 1'b0;
      if (rst_cyc > 0 && cyc == rst_cyc) reset = 1'b1;
      @(posedge clk); #1;
    end
    check_eq({tag, " done pulses"}, 64'(done_n), 64'(exp_done_cyc > 0 ? 1 : 0));
    check_eq({tag, " busy cycles"}, 64'(busy_n), 64'(exp_busy_n));
    if (exp_done_cyc > 0) begin
      check_eq({tag, " done cycle"}, 64'(done_at), 64'(exp_done_cyc));
      check_eq({tag, " hi"}, 64'(got_hi), 64'(exp_hi));
      check_eq({tag, " lo"}, 64'(got_lo), 64'(exp_lo));
      check_eq({tag, " dbz"}, 64'(got_dbz), 64'(exp_dbz));
    end
    check_eq({tag, " held"}, {hi, lo}, {exp_hi, exp_lo});
    check_eq({tag, " idle"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op_div = 1'b0; rs_val = '0; rt_val = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset state", 64'(dbg_state), 64'(ST_IDLE));
    check_eq("reset outs", {busy, done, div_by_zero, hi, lo}, 64'd0);
    reset = 1'b0;

    run_op("mul 7x6",     OP_MULU, 32'd7, 32'd6, 0, 0, 33, 32, 32'd0, 32'd42, 1'b0);
    run_op("mul max",     OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 33, 32,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mul shift",   OP_MULU, 32'h1234_5678, 32'h10, 0, 0, 33, 32,
           32'h0000_0001, 32'h2345_6780, 1'b0);
    run_op("div 100/7",   OP_DIVU, 32'd100, 32'd7, 0, 0, 33, 32, 32'd2, 32'd14, 1'b0);
    run_op("div 5/0",     OP_DIVU, 32'd5, 32'd0, 0, 0, 1, 0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    run_op("div max/16",  OP_DIVU, 32'hFFFF_FFFF, 32'h10, 0, 0, 33, 32,
           32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
    run_op("div 3/7",     OP_DIVU, 32'd3, 32'd7, 0, 0, 33, 32, 32'd3, 32'd0, 1'b0);
    run_op("mul ignore",  OP_MULU, 32'd7, 32'd6, 10, 0, 33, 32, 32'd0, 32'd42, 1'b0);
    run_op("div reset",   OP_DIVU, 32'd100, 32'd7, 0, 12, 0, 12, 32'd0, 32'd0, 1'b0);
    run_op("mul after",   OP_MULU, 32'd7, 32'd6, 0, 0, 33, 32, 32'd0, 32'd42, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits; the iteration count SHALL equal WIDTH.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op_div  input  1  0 = unsigned multiply, 1 = unsigned divide.
REQ-006 rs_val  input  WIDTH  multiplicand / dividend, taken from register-file read port 1.
REQ-007 rt_val  input  WIDTH  multiplier / divisor, taken from register-file read port 2.
REQ-008 busy  output  1  high while an operation is iterating.
REQ-009 done  output  1  one-cycle pulse marking valid results.
REQ-010 hi  output  WIDTH  product upper half / remainder.
REQ-011 lo  output  WIDTH  product lower half / quotient.
REQ-012 div_by_zero  output  1  set when the last divide had rt_val == 0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 IDLE with start=1 at the end of cycle N: latch rs_val, rt_val and op_div; clear the counter; go to RUN in cycle N+1.
REQ-015 Exception to REQ-014: if op_div=1 and rt_val==0, go directly to DONE in cycle N+1, with lo=all-ones, hi=dividend, div_by_zero=1.
REQ-016 RUN: perform one iteration per cycle for WIDTH cycles (N+1..N+WIDTH); enter DONE in cycle N+WIDTH+1.
REQ-017 Multiply SHALL use shift-add over a 2*WIDTH accumulator; the result is the exact unsigned product {hi,lo}.
REQ-018 Divide SHALL use restoring shift-subtract with a WIDTH+1-bit partial remainder; lo=quotient, hi=remainder.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-020 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-021 start SHALL be ignored in RUN and DONE; no queuing; latched operands SHALL be unaffected.
REQ-022 hi, lo and div_by_zero SHALL hold their values from DONE until the next accepted start.
REQ-023 Accepting a start SHALL clear div_by_zero; hi and lo are undefined-but-stable during RUN.
REQ-024 The counter SHALL be clog2(WIDTH)+1 bits wide and SHALL NOT wrap within an operation.
REQ-025 Operand changes after the accept edge SHALL NOT affect the result.

Reset
REQ-026 reset=1 at a rising edge SHALL force IDLE and busy=0, done=0, hi=0, lo=0, div_by_zero=0, counter=0, from any state.
REQ-027 reset SHALL take priority over start; an operation interrupted mid-RUN SHALL produce no done pulse.

Structure
REQ-028 The shared package SHALL hold the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the op_div encodings (OP_MULU=0, OP_DIVU=1).
REQ-029 One sub-module, md_step, SHALL implement a single combinational iteration (add-shift or compare-subtract-shift); the top SHALL hold the FSM, counter and registers.
REQ-030 The block SHALL contain no negedge logic; it feeds the register-file write port (write_data) externally.

Verification (WIDTH=32)
REQ-031 start, op_div=0, rs=7, rt=6 in cycle 0 -> busy high cycles 1..32; done in cycle 33; hi=0, lo=42.
REQ-032 Multiply 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 in cycle 33.
REQ-033 Divide 100/7 -> lo=14, hi=2, div_by_zero=0 in cycle 33.
REQ-034 Divide 5/0 -> done in cycle 1 with lo=0xFFFFFFFF, hi=5, div_by_zero=1; busy never high.
REQ-035 Second start with different operands in cycle 10 of a 7*6 multiply -> ignored; cycle 33 result still lo=42; exactly one done pulse.
REQ-036 reset asserted in cycle 12 of a running divide -> cycle 13 in IDLE with all outputs 0; no done pulse; a fresh start then completes normally.
